instr_dcd: RTL
==============

# instr_dcd

Instruction decoder between the SPI bridge and the PWM register file. It turns the byte stream from the SPI bridge into two-byte register transactions and drives the register file's `read`/`write`/`addr`/`data_write` bus. It adds a `hi_sel` section select so 16-bit registers can be written and read one byte at a time. It also captures read data and hands it back to the bridge for shifting out on the second byte of the frame.

## Interface
Parameters:
- `ADDR_W`, 6, register address width; equals the command byte bits [5:0].

Ports:
- `clk` in 1: the block's only clock.
- `rst` in 1: reset, synchronous and active-high.
- `byte_sync` in 1: one-cycle pulse from the SPI bridge; `data_in` holds a complete byte in that cycle.
- `data_in` in 8: received byte.
- `data_out` out 8: byte the SPI bridge shifts out during the next byte slot.
- `read` out 1: read strobe to the register file.
- `write` out 1: write strobe to the register file.
- `addr` out ADDR_W: register address.
- `hi_sel` out 1: section select; 1 selects byte [15:8], 0 selects byte [7:0].
- `data_write` out 8: write data to the register file.
- `data_read` in 8: read data from the register file; valid one cycle after `read` rises, while `read` stays high.

## Operation
- A frame is two bytes: a command byte, then a data byte.
- Command byte layout:
  - bit7: 1 = write, 0 = read.
  - bit6: the `hi_sel` value.
  - bits[5:0]: `addr`.
- States:
  - IDLE: wait for the command byte.
  - RD_ISSUE
  - RD_CAPTURE
  - WAIT_DATA
  - WR_PULSE
- IDLE + `byte_sync`:
  - Latch `addr` = data_in[5:0], `hi_sel` = data_in[6], and the write flag = data_in[7].
  - If the byte is a read command, go to RD_ISSUE; if it is a write command, go to WAIT_DATA.
- RD_ISSUE: `read`=1; go to RD_CAPTURE.
- RD_CAPTURE:
  - `read`=1.
  - `data_out` <= `data_read` at the clock edge.
  - Go to WAIT_DATA.
- WAIT_DATA + `byte_sync`:
  - Write frame: `data_write` <= data_in; go to WR_PULSE.
  - Read frame: the byte is a dummy; go to IDLE.
- WR_PULSE:
  - `write`=1 for exactly one cycle, with `addr`/`hi_sel`/`data_write` stable.
  - Go to IDLE.
- `addr` and `hi_sel` hold their values from the command-byte latch until the next command byte; they do not return to 0 between frames.
- `data_out` holds the last captured read data. It changes only in RD_CAPTURE or on reset, so write frames return the previous read value.
- `read` and `write` are never high in the same cycle.
- Boundary conditions:
  - `byte_sync` in RD_ISSUE or RD_CAPTURE (data byte arrives early): set a pending flag. The read sequence still completes. On entry to WAIT_DATA with the flag set, go straight to IDLE and clear the flag; no extra strobe.
  - `byte_sync` in WR_PULSE: treat as a command byte, exactly as in IDLE. The write pulse still completes.
  - Address outside the implemented map: strobes are issued unchanged; the register file ignores them.
  - `rst` mid-frame: abort the frame, return to IDLE, issue no `write`, clear the pending flag.

## Timing
- Reset values: `read`=0, `write`=0, `addr`=0, `hi_sel`=0, `data_write`=0x00, `data_out`=0x00, state IDLE, pending flag 0.
- All outputs are registered; there is no combinational path from `data_in` or `byte_sync` to any output.
- Read frame, command `byte_sync` at cycle T:
  - `read`=1 in cycles T+1 and T+2.
  - `data_out` is valid from T+3.
  - Minimum gap before the data byte is 3 cycles; the SPI byte period is at least 8 cycles, so this is always met.
- Write frame, data `byte_sync` at cycle T: `write`=1 in cycle T+1 only.
- Throughput: one frame per two `byte_sync` pulses, with no dead cycles required.

## Test plan
- Write low byte: bytes 0x80, 0x34 -> one cycle with `write`=1, `addr`=0x00, `hi_sel`=0, `data_write`=0x34; `read` stays 0.
- Write high byte: bytes 0xC3, 0x12 -> `write` pulse with `addr`=0x03, `hi_sel`=1, `data_write`=0x12.
- Read, with the register model returning 0x5A for addr 0x0A:
  - Bytes 0x0A then 0x00.
  - Expect `read`=1 for exactly 2 cycles and `data_out`=0x5A at T+3.
  - No `write` pulse.
- Reset mid-frame: bytes 0x82, then `rst` before the data byte, then 0x01 -> no `write` pulse; all outputs at reset values. The 0x01 is decoded as a read command of addr 0x01.
- Early data byte: `byte_sync` for the read data byte asserted in RD_CAPTURE -> `data_out` still captured; FSM in IDLE at T+3. The next byte 0x8C, 0x01 produces a `write` to `addr`=0x0C.
- Back-to-back: command `byte_sync` in the WR_PULSE cycle of the previous write -> both transactions complete with correct `addr` and `data_write`.

Source files
------------

// File: rtl/instr_dcd.sv
// instr_dcd: two-byte SPI frame decoder driving the PWM register file bus.
//
// A frame is a command byte {wr, hi_sel, addr[5:0]} followed by a data byte.
// Write frames produce a single-cycle write strobe after the data byte.
// Read frames strobe read for two cycles right after the command byte and
// capture data_read into data_out, which the bridge shifts out while the
// dummy data byte comes in.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   byte_sync       one-cycle pulse: data_in holds a complete byte
//   data_in[7:0]    received byte
//   data_out[7:0]   last captured read data, shifted out next byte slot
//   read, write     register file strobes (registered, never both high)
//   addr, hi_sel    register address and byte-section select
//   data_write[7:0] register file write data
//   data_read[7:0]  register file read data, valid one cycle after read rises
module instr_dcd #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic              hi_sel,
  output logic [7:0]        data_write,
  input  logic [7:0]        data_read
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_CAPTURE = 3'd2,
    WAIT_DATA  = 3'd3,
    WR_PULSE   = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   wr_flag;
  logic   pend, pend_nxt;
  logic   cmd_lat;
  logic   dat_lat;

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    cmd_lat   = 1'b0;
    dat_lat   = 1'b0;
    case (state)
      IDLE: begin
        if (byte_sync) begin
          cmd_lat   = 1'b1;
          state_nxt = data_in[7] ? WAIT_DATA : RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        // Data byte arrived before the read finished: remember it so the
        // frame closes as soon as the capture is done.
        if (byte_sync) pend_nxt = 1'b1;
        state_nxt = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        // The WAIT_DATA visit is skipped when the dummy byte is already in.
        if (pend || byte_sync) begin
          state_nxt = IDLE;
          pend_nxt  = 1'b0;
        end else begin
          state_nxt = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (byte_sync) begin
          dat_lat   = wr_flag;
          state_nxt = wr_flag ? WR_PULSE : IDLE;
        end
      end
      WR_PULSE: begin
        // A byte here is the next frame's command; the pulse cycle itself
        // is unaffected because addr/hi_sel only update at its end.
        state_nxt = IDLE;
        if (byte_sync) begin
          cmd_lat   = 1'b1;
          state_nxt = data_in[7] ? WAIT_DATA : RD_ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= 1'b0;
      wr_flag    <= 1'b0;
      addr       <= '0;
      hi_sel     <= 1'b0;
      data_write <= 8'h00;
      data_out   <= 8'h00;
      read       <= 1'b0;
      write      <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      if (cmd_lat) begin
        addr    <= data_in[ADDR_W-1:0];
        hi_sel  <= data_in[6];
        wr_flag <= data_in[7];
      end
      if (dat_lat) data_write <= data_in;
      if (state == RD_CAPTURE) data_out <= data_read;
      // Strobes are registered from the next state so they line up with it.
      read  <= (state_nxt == RD_ISSUE) || (state_nxt == RD_CAPTURE);
      write <= (state_nxt == WR_PULSE);
    end
  end

endmodule
